// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of loader, instruction-memory and IF/ID signals around imem_fetch_ctrl.
// master = fetch controller, slave = loader/memory/pipeline environment.
interface imem_fetch_ctrl_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [31:0] pc_out;
  logic        halted;

  modport master (
    input  load_valid, load_data, load_last, imem_rdata,
           stall, branch_taken, branch_target,
    output load_ready, imem_we, imem_addr, imem_wdata,
           if_id_valid, if_id_instr, if_id_pc4, pc_out, halted
  );

  modport slave (
    output load_valid, load_data, load_last, imem_rdata,
           stall, branch_taken, branch_target,
    input  load_ready, imem_we, imem_addr, imem_wdata,
           if_id_valid, if_id_instr, if_id_pc4, pc_out, halted
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: boot-loads the memory, then fetches into IF/ID.
// Optional FETCH_PROFILE_EN adds saturating fetch_count/stall_count outputs.
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  imem_fetch_ctrl_if.master bus,
  output logic [1:0]        state_dbg
`ifdef FETCH_PROFILE_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int unsigned CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;

  logic             load_accept;
  logic             load_done;
  logic             pc_oor;
  logic             run_stall;
  logic             run_fetch;
  logic [31:0]      load_addr;

  // Loader handshake: a word transfers on any rising edge where load_valid
  // and load_ready are both high; load_ready is high for the whole LOAD state
  // and the loader must hold data/last stable while load_valid waits.
  assign load_accept = (state_q == S_LOAD) && bus.load_valid;
  assign load_done   = load_accept &&
                       (bus.load_last || (cnt_q == CNT_W'(DEPTH - 1)));
  assign pc_oor      = (pc_q >= PC_LIMIT);
  assign load_addr   = 32'(cnt_q) << 2;

  assign run_stall = (state_q == S_RUN) && bus.stall && !bus.branch_taken;
  assign run_fetch = (state_q == S_RUN) && !bus.branch_taken && !pc_oor &&
                     !bus.stall && (bus.imem_rdata != HALT_WORD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      S_LOAD: begin
        if (load_done) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end else if (load_accept) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.branch_taken) begin
          // Misaligned targets are forced onto a word boundary.
          pc_d    = {bus.branch_target[31:2], 2'b00};
          valid_d = 1'b0;
          instr_d = '0;
        end else if (pc_oor) begin
          valid_d = 1'b0;
          state_d = S_HALT;
        end else if (bus.stall) begin
          valid_d = valid_q;
        end else if (bus.imem_rdata == HALT_WORD) begin
          // The halt word itself never enters IF/ID.
          valid_d = 1'b0;
          state_d = S_HALT;
        end else begin
          instr_d = bus.imem_rdata;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.load_ready  = (state_q == S_LOAD);
  assign bus.imem_we     = load_accept;
  assign bus.imem_addr   = (state_q == S_LOAD) ? load_addr : pc_q;
  assign bus.imem_wdata  = bus.load_data;
  assign bus.if_id_valid = valid_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.pc_out      = pc_q;
  assign bus.halted      = (state_q == S_HALT);
  assign state_dbg       = state_q;

`ifdef FETCH_PROFILE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (run_fetch && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (run_stall && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic unused_profile;
  assign unused_profile = run_fetch ^ run_stall;
`endif

endmodule
